// File: rtl/vending_machine.sv
// Four-item coin vending controller: item latched at the first coin, one-cycle dispense pulse carrying the change.
// Latency: out/change/state registered, visible one clk-to-q after the price-completing coin edge. No backpressure: coins offered in DISPENSE/REFUND are dropped.
// Optional cancel/refund path enabled by defining VM_CANCEL_EN.
module vending_machine #(
  parameter int PRICE_GRAPE     = 15,
  parameter int PRICE_ORANGE    = 35,
  parameter int PRICE_MANGO     = 25,
  parameter int PRICE_PINEAPPLE = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_vld,
  input  logic [4:0] itemS,
  input  logic [4:0] val,
`ifdef VM_CANCEL_EN
  input  logic       cancel,
`endif
  output logic       out,
  output logic [4:0] change,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    IDLE     = 5'd0,
    COLLECT  = 5'd1,
    DISPENSE = 5'd2,
    REFUND   = 5'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic [5:0] price_q, price_d;
  logic       out_d;
  logic [4:0] change_d;

  logic       coin_ok;
  logic       item_ok;
  logic [5:0] coin_amt;
  logic [5:0] sum;
  logic [5:0] item_price;
  logic       cancel_req;

  assign coin_ok  = coin_vld && ((val == 5'd5) || (val == 5'd10) || (val == 5'd20));
  assign coin_amt = {1'b0, val};
  assign sum      = credit_q + coin_amt;

`ifdef VM_CANCEL_EN
  assign cancel_req = cancel;
`else
  assign cancel_req = 1'b0;
`endif

  always_comb begin
    item_ok    = 1'b1;
    item_price = 6'd0;
    case (itemS)
      5'd1:    item_price = 6'(PRICE_GRAPE);
      5'd2:    item_price = 6'(PRICE_ORANGE);
      5'd3:    item_price = 6'(PRICE_MANGO);
      5'd4:    item_price = 6'(PRICE_PINEAPPLE);
      default: item_ok    = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    out_d    = 1'b0;
    change_d = 5'd0;
    case (state_q)
      IDLE: begin
        if (coin_ok && item_ok) begin
          price_d  = item_price;
          credit_d = coin_amt;
          if (coin_amt >= item_price) begin
            state_d  = DISPENSE;
            out_d    = 1'b1;
            change_d = 5'(coin_amt - item_price);
          end else begin
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        // Cancel wins over a coin arriving on the same edge.
        if (cancel_req) begin
          state_d  = REFUND;
          change_d = 5'(credit_q);
          credit_d = 6'd0;
        end else if (coin_ok) begin
          credit_d = sum;
          if (sum >= price_q) begin
            state_d  = DISPENSE;
            out_d    = 1'b1;
            change_d = 5'(sum - price_q);
          end
        end
      end
      DISPENSE: begin
        state_d  = IDLE;
        credit_d = 6'd0;
      end
`ifdef VM_CANCEL_EN
      REFUND: begin
        state_d  = IDLE;
        credit_d = 6'd0;
      end
`endif
      default: begin
        state_d  = IDLE;
        credit_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= 6'd0;
      price_q  <= 6'd0;
      out      <= 1'b0;
      change   <= 5'd0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      out      <= out_d;
      change   <= change_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: directed vector table, cancel sequence (VM_CANCEL_EN), then random traffic against a credit/price model.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_vld;
  logic [4:0] itemS;
  logic [4:0] val;
  logic       out;
  logic [4:0] change;
  logic [4:0] state;
`ifdef VM_CANCEL_EN
  logic       cancel;
  localparam bit CANCEL_BUILT = 1'b1;
`else
  localparam bit CANCEL_BUILT = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_machine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .coin_vld (coin_vld),
    .itemS    (itemS),
    .val      (val),
`ifdef VM_CANCEL_EN
    .cancel   (cancel),
`endif
    .out      (out),
    .change   (change),
    .state    (state)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       cv;
    logic [4:0] item;
    logic [4:0] val;
    logic [4:0] st;
    logic       o;
    logic [4:0] ch;
  } vec_t;

  vec_t vecs[$];

  // Purchase model: a sale is open from the first accepted coin until credit covers the price.
  bit m_busy;
  int m_credit;
  int m_price;
  int m_after;  // 0 = nothing pending, 2 = dispensed last edge, 3 = refunded last edge
  int e_state, e_out, e_chg;

  function automatic int price_of(input int item);
    case (item)
      1: return 15;
      2: return 35;
      3: return 25;
      4: return 30;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit cv, input int item, input int v, input bit cn);
    bit legal;
    e_out = 0;
    e_chg = 0;
    if (!r) begin
      m_busy = 0; m_credit = 0; m_after = 0; e_state = 0;
      return;
    end
    if (m_after != 0) begin
      m_after = 0; m_credit = 0; e_state = 0;
      return;
    end
    if (CANCEL_BUILT && m_busy && cn) begin
      e_chg = m_credit; m_credit = 0; m_busy = 0; m_after = 3; e_state = 3;
      return;
    end
    legal = cv && (v == 5 || v == 10 || v == 20);
    if (legal) begin
      if (!m_busy && price_of(item) > 0) begin
        m_busy = 1; m_price = price_of(item); m_credit = v;
      end else if (m_busy) begin
        m_credit += v;
      end
    end
    if (m_busy && m_credit >= m_price) begin
      e_out = 1; e_chg = m_credit - m_price; m_credit = 0; m_busy = 0; m_after = 2;
    end
    e_state = (m_after != 0) ? m_after : (m_busy ? 1 : 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, advances one edge, and updates the model.
  task automatic step(input bit r, input bit cv, input logic [4:0] item, input logic [4:0] v, input bit cn);
    rst_n    = r;
    coin_vld = cv;
    itemS    = item;
    val      = v;
`ifdef VM_CANCEL_EN
    cancel   = cn;
`endif
    model_edge(r, cv, int'(item), int'(v), cn);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input bit r, input bit cv, input int item, input int v,
                     input int st, input bit o, input int ch);
    vec_t t;
    t.name = n; t.rst_n = r; t.cv = cv; t.item = 5'(item); t.val = 5'(v);
    t.st = 5'(st); t.o = o; t.ch = 5'(ch);
    vecs.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; coin_vld = 1'b0; itemS = 5'd0; val = 5'd0;
`ifdef VM_CANCEL_EN
    cancel = 1'b0;
`endif
    m_busy = 0; m_credit = 0; m_price = 0; m_after = 0;
    e_state = 0; e_out = 0; e_chg = 0;

    add("reset",         0, 0, 0, 0,  0, 0, 0);
    add("orange_c10",    1, 1, 2, 10, 1, 0, 0);
    add("orange_c20",    1, 1, 2, 20, 1, 0, 0);
    add("orange_c10_dsp",1, 1, 2, 10, 2, 1, 5);
    add("orange_idle",   1, 0, 0, 0,  0, 0, 0);
    add("exact_c5",      1, 1, 1, 5,  1, 0, 0);
    add("exact_c10",     1, 1, 1, 10, 2, 1, 0);
    add("exact_idle",    1, 0, 0, 0,  0, 0, 0);
    add("direct_c20",    1, 1, 1, 20, 2, 1, 5);
    add("dsp_coin_drop", 1, 1, 1, 10, 0, 0, 0);
    add("no_carry_c5",   1, 1, 1, 5,  1, 0, 0);
    add("no_carry_c10",  1, 1, 1, 10, 2, 1, 0);
    add("no_carry_idle", 1, 0, 0, 0,  0, 0, 0);
    add("illegal_val7",  1, 1, 1, 7,  0, 0, 0);
    add("illegal_item0", 1, 1, 0, 10, 0, 0, 0);
    add("illegal_item6", 1, 1, 6, 20, 0, 0, 0);
    add("latch_mango",   1, 1, 3, 10, 1, 0, 0);
    add("collect_val7",  1, 1, 4, 7,  1, 0, 0);
    add("latch_c10",     1, 1, 4, 10, 1, 0, 0);
    add("latch_dsp",     1, 1, 4, 10, 2, 1, 5);
    add("latch_idle",    1, 0, 0, 0,  0, 0, 0);
    add("max_c10",       1, 1, 2, 10, 1, 0, 0);
    add("max_c20",       1, 1, 2, 20, 1, 0, 0);
    add("max_chg15",     1, 1, 2, 20, 2, 1, 15);
    add("max_idle",      1, 0, 0, 0,  0, 0, 0);
    add("mid_c20",       1, 1, 4, 20, 1, 0, 0);
    add("mid_reset",     0, 1, 4, 20, 0, 0, 0);
    add("post_rst_c20",  1, 1, 4, 20, 1, 0, 0);
    add("post_rst_c10",  1, 1, 4, 10, 2, 1, 0);
    add("post_rst_idle", 1, 0, 0, 0,  0, 0, 0);
    add("vld0_c5",       1, 1, 4, 5,  1, 0, 0);
    add("vld0_novld",    1, 0, 4, 20, 1, 0, 0);
    add("vld0_c20",      1, 1, 4, 20, 1, 0, 0);
    add("vld0_c5_dsp",   1, 1, 4, 5,  2, 1, 0);
    add("vld0_idle",     1, 0, 0, 0,  0, 0, 0);

    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].cv, vecs[i].item, vecs[i].val, 1'b0);
      chk({vecs[i].name, ".state"},  int'(state),  int'(vecs[i].st));
      chk({vecs[i].name, ".out"},    int'(out),    int'(vecs[i].o));
      chk({vecs[i].name, ".change"}, int'(change), int'(vecs[i].ch));
    end

`ifdef VM_CANCEL_EN
    step(1'b1, 1'b1, 5'd2, 5'd10, 1'b0);
    step(1'b1, 1'b1, 5'd2, 5'd20, 1'b0);
    step(1'b1, 1'b1, 5'd2, 5'd5, 1'b1);
    chk("cancel.state",  int'(state),  3);
    chk("cancel.out",    int'(out),    0);
    chk("cancel.change", int'(change), 30);
    step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    chk("cancel_after.state",  int'(state),  0);
    chk("cancel_after.change", int'(change), 0);
    step(1'b1, 1'b1, 5'd1, 5'd5, 1'b1);
    chk("cancel_idle.state", int'(state), 1);
    step(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
`endif

    for (int n = 0; n < 600; n++) begin
      bit r, cv, cn;
      logic [4:0] it, v;
      int pick;
      r    = ($urandom_range(0, 39) != 0);
      cv   = ($urandom_range(0, 1) == 1);
      it   = 5'($urandom_range(0, 6));
      pick = $urandom_range(0, 5);
      case (pick)
        0: v = 5'd5;
        1: v = 5'd10;
        2: v = 5'd20;
        3: v = 5'd7;
        4: v = 5'd15;
        default: v = 5'd20;
      endcase
      cn = CANCEL_BUILT && ($urandom_range(0, 7) == 0);
      step(r, cv, it, v, cn);
      chk("rand.state",  int'(state),  e_state);
      chk("rand.out",    int'(out),    e_out);
      chk("rand.change", int'(change), e_chg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
